goertzel_seq_ctrl: RTL and testbench
====================================

Name: goertzel_seq_ctrl

Overview:
Run sequencer for the Goertzel filter bank. It takes start/abort/config from the AXI register block and sequences one measurement: filter clear, CORDIC coefficient computation, gating of exactly num_samp input samples into the filter bank, and collection of all NF results. It replaces direct software toggling of reset_h/en_cordic and flags timeouts and configuration errors. Continuous mode re-arms automatically without recomputing coefficients.

Parameters:
NF, 11, number of Goertzel filters (width of valid_herzel_i)
CLR_CYC, 4, cycles reset_h_o is held high in CLR (>=1)
TMO_W, 24, width of timeout counter
TMO_CYC, 24'hFF_FFFF, timeout in cycles for COEF and WRES states; 0 disables timeout

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start_i  in  1  run request, sampled only in IDLE/ERR/DONE
abort_i  in  1  abort run, highest priority
cont_i  in  1  continuous mode: DONE re-enters CLR automatically
num_samp_i  in  32  samples per run, latched on start
samp_stb_i  in  1  one-cycle strobe per new input sample
valid_angel_i  in  1  angle computation complete
valid_cordic_i  in  1  CORDIC coefficients valid
valid_herzel_i  in  NF  per-filter result valid
reset_h_o  out  1  filter-bank clear
en_cordic_o  out  1  CORDIC enable
samp_en_o  out  1  sample gate into filters
last_samp_o  out  1  marks final gated sample
samp_cnt_o  out  32  samples gated this run
busy_o  out  1  run in progress
done_o  out  1  one-cycle run-complete pulse
res_valid_o  out  1  results stable, level
err_o  out  1  sticky error
err_code_o  out  2  01 num_samp=0, 10 COEF timeout, 11 WRES timeout
state_o  out  3  current state encoding

Behaviour:
- States/encoding: IDLE=0, CLR=1, COEF=2, ACCUM=3, WRES=4, DONE=5, ERR=6. Single registered FSM on posedge clk.
- Reset: state IDLE; all outputs 0; samp_cnt_o 0; coef_ok flag 0; num_samp_q 0.
- IDLE/ERR: start_i=1 -> latch num_samp_q; if num_samp_i==0 -> ERR, err_code 01 (next cycle); else -> CLR, clear err_o/err_code_o/res_valid_o/samp_cnt_o.
- CLR: reset_h_o=1 for exactly CLR_CYC cycles; then -> ACCUM if coef_ok, else -> COEF.
- COEF: en_cordic_o=1 (set on entry, held through ACCUM/WRES/DONE); wait valid_angel_i && valid_cordic_i -> set coef_ok, -> ACCUM. Timeout counter reaching TMO_CYC -> ERR, code 10.
- ACCUM: samp_en_o = samp_stb_i && state==ACCUM && !abort_i (combinational, zero latency). Each gated strobe increments samp_cnt_o. Strobe when samp_cnt_o==num_samp_q-1 also asserts last_samp_o (same cycle) -> WRES next cycle. Strobes outside ACCUM are ignored. No timeout in ACCUM.
- WRES: wait &valid_herzel_i -> DONE; timeout -> ERR, code 11. Timeout counter cleared on every state entry.
- DONE (1 cycle): done_o=1, res_valid_o set (level). Next: cont_i -> CLR (coef_ok kept, res_valid_o stays 1 until CLR exit... cleared on CLR entry); else start_i -> CLR, else -> IDLE holding res_valid_o.
- ERR: err_o=1, en_cordic_o=0, coef_ok cleared; stays until start_i or abort_i.
- abort_i: from any state -> IDLE next cycle; clears err, res_valid, coef_ok, counters, en_cordic_o. Abort with start same cycle -> IDLE. Abort with final strobe same cycle -> no samp_en_o/last_samp_o.
- busy_o = state in {CLR, COEF, ACCUM, WRES, DONE}.
- num_samp_i changes mid-run ignored; samp_cnt_o 32-bit, cannot wrap since bounded by num_samp_q.

Test Plan:
- Basic run: NF=3, num_samp=5, valid_angel/cordic at cycle 10 of COEF, 5 strobes, valid_herzel=3'b111 -> reset_h 4 cycles, en_cordic 1, samp_en 5 pulses, last_samp on 5th, done_o one pulse, res_valid 1, samp_cnt 5.
- Zero samples: num_samp=0, start -> state ERR next cycle, err_o=1, err_code 01, reset_h never asserted.
- Timeout: TMO_CYC=100, valid_cordic held 0 -> ERR after 100 COEF cycles, code 10, en_cordic 0; start then recovers into CLR.
- Continuous: cont_i=1, num_samp=3 -> after DONE goes CLR->ACCUM skipping COEF, en_cordic stays 1, done_o pulses each run.
- Abort mid-ACCUM after 2 of 5 strobes, concurrent strobe -> no samp_en that cycle, IDLE next, samp_cnt 0, busy 0.
- Async reset during WRES -> all outputs 0 immediately, state 0.

Source files
------------

// File: rtl/goertzel_seq_ctrl.sv
// goertzel_seq_ctrl: run sequencer for the Goertzel bank (clear, coefficients, sample gating, result collection).
// Tracks timeouts and configuration errors; continuous mode re-arms without recomputing coefficients.
module goertzel_seq_ctrl #(
    parameter int               NF      = 11,
    parameter int               CLR_CYC = 4,
    parameter int               TMO_W   = 24,
    parameter logic [TMO_W-1:0] TMO_CYC = 24'hFF_FFFF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          cont_i,
    input  logic [31:0]   num_samp_i,
    input  logic          samp_stb_i,
    input  logic          valid_angel_i,
    input  logic          valid_cordic_i,
    input  logic [NF-1:0] valid_herzel_i,
    output logic          reset_h_o,
    output logic          en_cordic_o,
    output logic          samp_en_o,
    output logic          last_samp_o,
    output logic [31:0]   samp_cnt_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          res_valid_o,
    output logic          err_o,
    output logic [1:0]    err_code_o,
    output logic [2:0]    state_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_COEF  = 3'd2;
    localparam logic [2:0] S_ACCUM = 3'd3;
    localparam logic [2:0] S_WRES  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [31:0]      num_samp_q, num_samp_d;
    logic [31:0]      samp_cnt_q, samp_cnt_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             coef_ok_q, coef_ok_d;
    logic             en_cordic_q, en_cordic_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             res_valid_q, res_valid_d;
    logic             samp_en, last_samp, tmo_hit, clr_end, start_run;

    // One cycle counter serves both the CLR hold and the COEF/WRES timeout; it restarts on every state entry.
    assign samp_en   = samp_stb_i && (state_q == S_ACCUM) && !abort_i;
    assign last_samp = samp_en && (samp_cnt_q == num_samp_q - 32'd1);
    assign tmo_hit   = (TMO_CYC != '0) && (cnt_q == TMO_CYC - 1'b1);
    assign clr_end   = cnt_q == TMO_W'(CLR_CYC - 1);
    assign start_run = start_i && ((state_q == S_IDLE) || (state_q == S_ERR) || ((state_q == S_DONE) && !cont_i));

    always_comb begin
        state_d     = state_q;
        num_samp_d  = num_samp_q;
        samp_cnt_d  = samp_cnt_q;
        coef_ok_d   = coef_ok_q;
        en_cordic_d = en_cordic_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        res_valid_d = res_valid_q;
        case (state_q)
            S_IDLE, S_ERR: state_d = start_i ? S_CLR : state_q;
            S_CLR:         state_d = clr_end ? (coef_ok_q ? S_ACCUM : S_COEF) : S_CLR;
            S_COEF: begin
                if (valid_angel_i && valid_cordic_i) state_d = S_ACCUM;
                else if (tmo_hit) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b10;
                end
            end
            S_ACCUM:       state_d = last_samp ? S_WRES : S_ACCUM;
            S_WRES: begin
                if (&valid_herzel_i) state_d = S_DONE;
                else if (tmo_hit) begin
                    state_d    = S_ERR;
                    err_code_d = 2'b11;
                end
            end
            S_DONE:        state_d = (cont_i || start_i) ? S_CLR : S_IDLE;
            default:       state_d = S_IDLE;
        endcase
        if (start_run) begin
            num_samp_d = num_samp_i;
            if (num_samp_i == 32'd0) begin
                state_d    = S_ERR;
                err_code_d = 2'b01;
            end
        end
        if (state_d == S_ERR && state_q != S_ERR) begin
            err_d       = 1'b1;
            en_cordic_d = 1'b0;
            coef_ok_d   = 1'b0;
        end
        if (state_d == S_CLR && state_q != S_CLR) begin
            err_d       = 1'b0;
            err_code_d  = 2'b00;
            res_valid_d = 1'b0;
            samp_cnt_d  = 32'd0;
        end
        if (state_d == S_COEF && state_q != S_COEF) en_cordic_d = 1'b1;
        if (state_q == S_COEF && state_d == S_ACCUM) coef_ok_d = 1'b1;
        if (state_d == S_DONE) res_valid_d = 1'b1;
        if (samp_en) samp_cnt_d = samp_cnt_q + 32'd1;
        if (abort_i) begin
            state_d     = S_IDLE;
            err_d       = 1'b0;
            err_code_d  = 2'b00;
            res_valid_d = 1'b0;
            coef_ok_d   = 1'b0;
            samp_cnt_d  = 32'd0;
            en_cordic_d = 1'b0;
        end
        cnt_d = (abort_i || state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            num_samp_q  <= '0;
            samp_cnt_q  <= '0;
            cnt_q       <= '0;
            coef_ok_q   <= 1'b0;
            en_cordic_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_samp_q  <= num_samp_d;
            samp_cnt_q  <= samp_cnt_d;
            cnt_q       <= cnt_d;
            coef_ok_q   <= coef_ok_d;
            en_cordic_q <= en_cordic_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign reset_h_o   = state_q == S_CLR;
    assign en_cordic_o = en_cordic_q;
    assign samp_en_o   = samp_en;
    assign last_samp_o = last_samp;
    assign samp_cnt_o  = samp_cnt_q;
    assign busy_o      = (state_q >= S_CLR) && (state_q <= S_DONE);
    assign done_o      = state_q == S_DONE;
    assign res_valid_o = res_valid_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_goertzel_seq_ctrl.sv
// tb_goertzel_seq_ctrl: directed runs with a scoreboard monitor for sample gating, done pulses, errors and clear length.
module tb_goertzel_seq_ctrl;
    localparam int NF = 3;
    logic clk = 1'b0, rstn = 1'b1;
    logic start_i = 0, abort_i = 0, cont_i = 0, samp_stb_i = 0, valid_angel_i = 0, valid_cordic_i = 0;
    logic [31:0] num_samp_i = '0;
    logic [NF-1:0] valid_herzel_i = '0;
    logic reset_h_o, en_cordic_o, samp_en_o, last_samp_o, busy_o, done_o, res_valid_o, err_o;
    logic [31:0] samp_cnt_o;
    logic [1:0] err_code_o;
    logic [2:0] state_o;

    goertzel_seq_ctrl #(.NF(NF), .CLR_CYC(4), .TMO_W(24), .TMO_CYC(24'd100)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .abort_i(abort_i), .cont_i(cont_i),
        .num_samp_i(num_samp_i), .samp_stb_i(samp_stb_i), .valid_angel_i(valid_angel_i),
        .valid_cordic_i(valid_cordic_i), .valid_herzel_i(valid_herzel_i), .reset_h_o(reset_h_o),
        .en_cordic_o(en_cordic_o), .samp_en_o(samp_en_o), .last_samp_o(last_samp_o),
        .samp_cnt_o(samp_cnt_o), .busy_o(busy_o), .done_o(done_o), .res_valid_o(res_valid_o),
        .err_o(err_o), .err_code_o(err_code_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit exp_last_q[$];
    int exp_done_q[$];
    logic [1:0] exp_err_q[$];
    int exp_clr_q[$];
    int clr_run = 0;
    logic err_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rstn) begin
            if (samp_en_o) begin
                if (exp_last_q.size() == 0) chk("unexpected samp_en", 1, 0);
                else chk("last_samp", {31'd0, last_samp_o}, {31'd0, exp_last_q.pop_front()});
            end else if (last_samp_o) chk("last_samp without samp_en", 1, 0);
            if (done_o) begin
                if (exp_done_q.size() == 0) chk("unexpected done", 1, 0);
                else begin
                    chk("done samp_cnt", samp_cnt_o, exp_done_q.pop_front());
                    chk("done res_valid", {31'd0, res_valid_o}, 1);
                end
            end
            if (err_o && !err_prev) begin
                if (exp_err_q.size() == 0) chk("unexpected err", 1, 0);
                else chk("err_code", {30'd0, err_code_o}, {30'd0, exp_err_q.pop_front()});
            end
            err_prev = err_o;
            if (reset_h_o) clr_run++;
            else if (clr_run > 0) begin
                if (exp_clr_q.size() == 0) chk("unexpected reset_h", 1, 0);
                else chk("reset_h cycles", clr_run, exp_clr_q.pop_front());
                clr_run = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] n);
        num_samp_i = n;
        start_i = 1;
        tick();
        start_i = 0;
    endtask

    task automatic strobe;
        samp_stb_i = 1;
        tick();
        samp_stb_i = 0;
        tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state_o !== s && n < budget) begin
            tick();
            n++;
        end
        chk(name, {29'd0, state_o}, {29'd0, s});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        #2 rstn = 0;
        #3;
        chk("reset state", {29'd0, state_o}, 0);
        chk("reset outputs", {24'd0, reset_h_o, en_cordic_o, samp_en_o, last_samp_o, busy_o, done_o, res_valid_o, err_o}, 0);
        chk("reset samp_cnt", samp_cnt_o, 0);
        @(negedge clk);
        rstn = 1;
        tick();

        // basic run, 5 samples
        exp_clr_q.push_back(4);
        go(5);
        chk("basic CLR", {29'd0, state_o}, 1);
        chk("basic busy", {31'd0, busy_o}, 1);
        wait_state(3'd2, 10, "basic enter COEF");
        chk("basic en_cordic", {31'd0, en_cordic_o}, 1);
        repeat (9) tick();
        valid_angel_i = 1;
        valid_cordic_i = 1;
        wait_state(3'd3, 5, "basic enter ACCUM");
        for (int i = 0; i < 5; i++) exp_last_q.push_back(i == 4);
        repeat (5) strobe();
        chk("basic WRES", {29'd0, state_o}, 4);
        chk("basic samp_cnt", samp_cnt_o, 5);
        samp_stb_i = 1;
        tick();
        samp_stb_i = 0;
        chk("stray strobe ignored", samp_cnt_o, 5);
        valid_herzel_i = 3'b011;
        tick();
        tick();
        chk("partial herzel holds WRES", {29'd0, state_o}, 4);
        exp_done_q.push_back(5);
        valid_herzel_i = 3'b111;
        tick();
        chk("basic DONE", {29'd0, state_o}, 5);
        valid_herzel_i = 0;
        tick();
        chk("basic IDLE", {29'd0, state_o}, 0);
        chk("basic res_valid held", {31'd0, res_valid_o}, 1);
        chk("basic idle busy", {31'd0, busy_o}, 0);
        valid_angel_i = 0;
        valid_cordic_i = 0;

        // zero samples
        exp_err_q.push_back(2'b01);
        go(0);
        chk("zero ERR", {29'd0, state_o}, 6);
        chk("zero err_o", {31'd0, err_o}, 1);
        chk("zero en_cordic", {31'd0, en_cordic_o}, 0);
        tick();
        chk("zero stays ERR", {29'd0, state_o}, 6);

        // COEF timeout
        exp_clr_q.push_back(4);
        go(5);
        wait_state(3'd2, 10, "tmo enter COEF");
        valid_angel_i = 1;
        exp_err_q.push_back(2'b10);
        n = 0;
        while (state_o == 3'd2 && n < 300) begin
            n++;
            tick();
        end
        chk("tmo COEF cycles", n, 100);
        chk("tmo ERR", {29'd0, state_o}, 6);
        chk("tmo en_cordic", {31'd0, en_cordic_o}, 0);
        valid_angel_i = 0;

        // continuous mode, two runs of 3
        cont_i = 1;
        exp_clr_q.push_back(4);
        go(3);
        chk("recover CLR", {29'd0, state_o}, 1);
        wait_state(3'd2, 10, "cont enter COEF");
        valid_angel_i = 1;
        valid_cordic_i = 1;
        wait_state(3'd3, 5, "cont enter ACCUM");
        for (int i = 0; i < 3; i++) exp_last_q.push_back(i == 2);
        exp_done_q.push_back(3);
        exp_clr_q.push_back(4);
        valid_herzel_i = 3'b111;
        repeat (3) strobe();
        wait_state(3'd5, 5, "cont DONE 1");
        valid_angel_i = 0;
        valid_cordic_i = 0;
        tick();
        chk("cont re-enter CLR", {29'd0, state_o}, 1);
        chk("cont res_valid cleared", {31'd0, res_valid_o}, 0);
        repeat (4) tick();
        chk("cont skips COEF", {29'd0, state_o}, 3);
        chk("cont en_cordic", {31'd0, en_cordic_o}, 1);
        for (int i = 0; i < 3; i++) exp_last_q.push_back(i == 2);
        exp_done_q.push_back(3);
        cont_i = 0;
        repeat (3) strobe();
        wait_state(3'd0, 10, "cont back to IDLE");
        chk("cont res_valid", {31'd0, res_valid_o}, 1);
        valid_herzel_i = 0;

        // abort mid-ACCUM with a concurrent strobe
        exp_clr_q.push_back(4);
        go(5);
        wait_state(3'd3, 10, "abort enter ACCUM");
        exp_last_q.push_back(0);
        exp_last_q.push_back(0);
        repeat (2) strobe();
        chk("abort pre count", samp_cnt_o, 2);
        abort_i = 1;
        samp_stb_i = 1;
        @(negedge clk);
        chk("abort blocks samp_en", {31'd0, samp_en_o}, 0);
        tick();
        abort_i = 0;
        samp_stb_i = 0;
        chk("abort IDLE", {29'd0, state_o}, 0);
        chk("abort samp_cnt", samp_cnt_o, 0);
        chk("abort busy", {31'd0, busy_o}, 0);
        chk("abort en_cordic", {31'd0, en_cordic_o}, 0);
        chk("abort res_valid", {31'd0, res_valid_o}, 0);

        // abort wins over start
        start_i = 1;
        abort_i = 1;
        num_samp_i = 4;
        tick();
        start_i = 0;
        abort_i = 0;
        chk("abort+start IDLE", {29'd0, state_o}, 0);
        chk("abort+start no clear", {31'd0, reset_h_o}, 0);

        // single-sample run, async reset during WRES
        valid_angel_i = 1;
        valid_cordic_i = 1;
        exp_clr_q.push_back(4);
        go(1);
        wait_state(3'd3, 12, "one enter ACCUM");
        exp_last_q.push_back(1);
        strobe();
        chk("one WRES", {29'd0, state_o}, 4);
        chk("one samp_cnt", samp_cnt_o, 1);
        #2 rstn = 0;
        #1;
        chk("async reset state", {29'd0, state_o}, 0);
        chk("async reset outputs", {22'd0, reset_h_o, en_cordic_o, samp_en_o, last_samp_o, busy_o, done_o, res_valid_o, err_o, err_code_o}, 0);
        chk("async reset samp_cnt", samp_cnt_o, 0);
        @(negedge clk);
        rstn = 1;
        tick();
        tick();
        chk("queues drained", exp_last_q.size() + exp_done_q.size() + exp_err_q.size() + exp_clr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
